// File: rtl/bnn_bus_master.sv
// Bus initiator for the BNN accelerator data port: runs ini / acc / pool / norm
// commands for one output word, then reads back the 32 activation bits.
module bnn_bus_master #(
   parameter int DRAIN_CYC = 3,
   parameter int NACC_W    = 10
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   output logic              busy,
   output logic              done,
   output logic              err,
   input  logic [15:0]       cfg_bias,
   input  logic [NACC_W-1:0] cfg_nacc,
   input  logic [2:0]        cfg_npool,
   input  logic [9:0]        cfg_prow,
   input  logic [9:0]        cfg_nrow,
   input  logic              cfg_norm8,
   input  logic              in_valid,
   input  logic [31:0]       in_data,
   output logic              in_ready,
   output logic              out_valid,
   output logic [31:0]       out_data,
   input  logic              out_ready,
   output logic              p_req,
   output logic              p_we,
   output logic [3:0]        p_be,
   output logic [31:0]       p_addr,
   output logic [31:0]       p_wdata,
   input  logic              p_gnt,
   input  logic              p_rvalid,
   input  logic [31:0]       p_rdata,
   input  logic              p_err
);

   typedef enum logic [3:0] {
      S_IDLE, S_INI, S_ACC_POP, S_ACC, S_POOL, S_NORM, S_DRAIN, S_READ, S_OUT
   } state_t;

   localparam int KW  = NACC_W + 1;
   localparam int DCW = (DRAIN_CYC > 1) ? $clog2(DRAIN_CYC) : 1;
   localparam logic [DCW-1:0] DRAIN_LAST = DCW'((DRAIN_CYC > 0) ? DRAIN_CYC - 1 : 0);

   state_t state, state_nx;

   logic [15:0]       bias_r;
   logic [NACC_W-1:0] nacc_r;
   logic [2:0]        npool_r;
   logic [9:0]        prow_r;
   logic [9:0]        nrow_r;
   logic              norm8_r;
   logic [NACC_W-1:0] k;
   logic [2:0]        pos;
   logic [31:0]       acc_word;
   logic              waiting;
   logic [DCW-1:0]    drain_cnt;
   logic [9:0]        row;
   logic              resp;
   logic              resp_ok;
   logic              last_k;
   logic              last_pos;

   // waiting marks a granted request whose response has not yet arrived
   assign resp     = waiting && p_rvalid;
   assign resp_ok  = resp && !p_err;
   assign row      = prow_r + 10'(k);
   assign last_k   = ({1'b0, k} + KW'(1)) >= {1'b0, nacc_r};
   assign last_pos = ({1'b0, pos} + 4'd1) >= {1'b0, npool_r};
   assign busy     = (state != S_IDLE);

   always_ff @(posedge clk) begin
      if (rst) state <= S_IDLE;
      else     state <= state_nx;
   end

   always_comb begin
      state_nx  = state;
      p_req     = 1'b0;
      p_we      = 1'b0;
      p_be      = 4'h0;
      p_addr    = 32'h0;
      p_wdata   = 32'h0;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      case (state)
         S_IDLE: begin
            if (start) state_nx = S_INI;
         end
         S_INI: begin
            p_req   = !waiting;
            p_we    = 1'b1;
            p_be    = 4'hF;
            p_addr  = 32'h0000_1000;
            p_wdata = {16'h0, bias_r};
            if (resp_ok) state_nx = (nacc_r == '0) ? S_POOL : S_ACC_POP;
         end
         S_ACC_POP: begin
            in_ready = 1'b1;
            if (in_valid) state_nx = S_ACC;
         end
         S_ACC: begin
            p_req   = !waiting;
            p_we    = 1'b1;
            p_be    = 4'hF;
            p_addr  = {20'h0, row, 2'b00};
            p_wdata = acc_word;
            if (resp_ok) state_nx = last_k ? S_POOL : S_ACC_POP;
         end
         S_POOL: begin
            p_req   = !waiting;
            p_we    = 1'b1;
            p_be    = 4'hF;
            p_addr  = 32'h0000_1004;
            p_wdata = {16'h0, bias_r};
            if (resp_ok) begin
               if (last_pos)             state_nx = S_NORM;
               else if (nacc_r == '0)    state_nx = S_POOL;
               else                      state_nx = S_ACC_POP;
            end
         end
         S_NORM: begin
            p_req  = !waiting;
            p_we   = 1'b1;
            p_be   = norm8_r ? 4'b1001 : 4'b1011;
            p_addr = {20'h0, nrow_r, 2'b00};
            if (resp_ok) state_nx = (DRAIN_CYC == 0) ? S_READ : S_DRAIN;
         end
         S_DRAIN: begin
            if (drain_cnt == DRAIN_LAST) state_nx = S_READ;
         end
         S_READ: begin
            p_req  = !waiting;
            p_be   = 4'hF;
            p_addr = 32'h0000_100C;
            if (resp_ok) state_nx = S_OUT;
         end
         S_OUT: begin
            out_valid = 1'b1;
            if (out_ready) state_nx = S_IDLE;
         end
         default: state_nx = S_IDLE;
      endcase
      // an error response aborts from any bus state
      if (resp && p_err) state_nx = S_IDLE;
      if (!p_req) begin
         p_we    = 1'b0;
         p_be    = 4'h0;
         p_addr  = 32'h0;
         p_wdata = 32'h0;
      end
   end

   // configuration, loop counters, bus handshake tracking and result capture
   always_ff @(posedge clk) begin
      if (rst) begin
         bias_r    <= '0;
         nacc_r    <= '0;
         npool_r   <= '0;
         prow_r    <= '0;
         nrow_r    <= '0;
         norm8_r   <= 1'b0;
         k         <= '0;
         pos       <= '0;
         acc_word  <= '0;
         waiting   <= 1'b0;
         drain_cnt <= '0;
         out_data  <= '0;
         done      <= 1'b0;
         err       <= 1'b0;
      end else begin
         done <= 1'b0;
         if (p_req && p_gnt)  waiting <= 1'b1;
         else if (resp)       waiting <= 1'b0;
         if (state == S_IDLE && start) begin
            bias_r  <= cfg_bias;
            nacc_r  <= cfg_nacc;
            npool_r <= (cfg_npool == 3'd0) ? 3'd1 : cfg_npool;
            prow_r  <= cfg_prow;
            nrow_r  <= cfg_nrow;
            norm8_r <= cfg_norm8;
            k       <= '0;
            pos     <= '0;
            err     <= 1'b0;
         end
         if (state == S_ACC_POP && in_valid) acc_word <= in_data;
         if (state == S_ACC && resp_ok)      k <= k + NACC_W'(1);
         if (state == S_POOL && resp_ok) begin
            pos <= pos + 3'd1;
            k   <= '0;
         end
         if (state == S_NORM)  drain_cnt <= '0;
         if (state == S_DRAIN) drain_cnt <= drain_cnt + DCW'(1);
         if (state == S_READ && resp_ok) out_data <= p_rdata;
         if (state == S_OUT && out_ready) done <= 1'b1;
         if (resp && p_err) begin
            err  <= 1'b1;
            done <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_bnn_bus_master.sv
// Self-checking bench for bnn_bus_master: randomized bus slave and streams,
// expected command sequence built from the configured loop structure.
module tb_bnn_bus_master;

   localparam int DRAIN_CYC = 3;
   localparam int NACC_W    = 10;

   typedef struct {
      logic        we;
      logic [3:0]  be;
      logic [31:0] addr;
      logic [31:0] wdata;
      int          gap;
   } txn_t;

   logic clk, rst, start, busy, done, err;
   logic [15:0] cfg_bias;
   logic [NACC_W-1:0] cfg_nacc;
   logic [2:0] cfg_npool;
   logic [9:0] cfg_prow, cfg_nrow;
   logic cfg_norm8;
   logic in_valid, in_ready, out_valid, out_ready;
   logic [31:0] in_data, out_data;
   logic p_req, p_we, p_gnt, p_rvalid, p_err;
   logic [3:0] p_be;
   logic [31:0] p_addr, p_wdata, p_rdata;

   int n_cmp = 0;
   int n_bad = 0;
   int cyc = 0;
   int gnt_min = 0, gnt_max = 0, rv_min = 0, rv_max = 0;
   int in_gap_min = 0, in_gap_max = 0;
   int out_mode = 2;
   int err_at = -1;
   int resp_idx = 0;
   int done_cnt = 0;
   logic [31:0] read_data = 32'h0;
   logic [31:0] exp_rdata;
   bit exp_err;

   txn_t got_q[$];
   txn_t exp_q[$];
   logic [31:0] in_q[$];
   logic [31:0] out_q[$];

   bnn_bus_master #(.DRAIN_CYC(DRAIN_CYC), .NACC_W(NACC_W)) dut (
      .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done), .err(err),
      .cfg_bias(cfg_bias), .cfg_nacc(cfg_nacc), .cfg_npool(cfg_npool),
      .cfg_prow(cfg_prow), .cfg_nrow(cfg_nrow), .cfg_norm8(cfg_norm8),
      .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
      .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
      .p_req(p_req), .p_we(p_we), .p_be(p_be), .p_addr(p_addr), .p_wdata(p_wdata),
      .p_gnt(p_gnt), .p_rvalid(p_rvalid), .p_rdata(p_rdata), .p_err(p_err)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string tag, input logic [71:0] obs, input logic [71:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // bus slave: random grant/response latency, logs every granted request
   initial begin : bus_slave
      int gnt_cnt, gnt_need, rv_cnt, first_gap, last_rv_cyc;
      bit pend, held, seen, pend_read;
      logic [68:0] held_f;
      txn_t t;
      p_gnt = 1'b0; p_rvalid = 1'b0; p_err = 1'b0; p_rdata = 32'h0;
      gnt_cnt = 0; gnt_need = 0; rv_cnt = 0; first_gap = 0; last_rv_cyc = 0;
      pend = 0; held = 0; seen = 0; pend_read = 0; held_f = '0;
      forever begin
         @(negedge clk);
         cyc++;
         p_gnt = 1'b0; p_rvalid = 1'b0; p_err = 1'b0;
         if (rst) begin
            pend = 0; held = 0; seen = 0; gnt_cnt = 0;
         end else begin
            if (held)
               check("req_stable", 72'({p_req, p_we, p_be, p_addr, p_wdata}), 72'({1'b1, held_f}));
            if (pend) begin
               check("req_while_outstanding", 72'(p_req), 72'(0));
               if (rv_cnt == 0) begin
                  p_rvalid = 1'b1;
                  p_err = (resp_idx == err_at);
                  p_rdata = pend_read ? read_data : $urandom;
                  resp_idx++;
                  pend = 0;
                  last_rv_cyc = cyc;
               end else rv_cnt--;
            end else if (p_req) begin
               if (!seen) begin
                  seen = 1;
                  gnt_need = $urandom_range(gnt_max, gnt_min);
                  first_gap = cyc - last_rv_cyc;
               end
               if (gnt_cnt >= gnt_need) begin
                  p_gnt = 1'b1;
                  t.we = p_we; t.be = p_be; t.addr = p_addr; t.wdata = p_wdata; t.gap = first_gap;
                  got_q.push_back(t);
                  pend = 1; pend_read = !p_we;
                  rv_cnt = $urandom_range(rv_max, rv_min);
                  gnt_cnt = 0; seen = 0;
               end else gnt_cnt++;
            end
            held = p_req && !p_gnt;
            held_f = {p_we, p_be, p_addr, p_wdata};
         end
      end
   end

   // input stream source with random idle gaps before each word
   initial begin : in_drv
      int gap;
      bit hs;
      in_valid = 1'b0; in_data = 32'h0; gap = 0; hs = 0;
      forever begin
         @(negedge clk);
         if (hs) begin
            if (in_q.size() > 0) void'(in_q.pop_front());
            in_valid = 1'b0; hs = 0;
            gap = $urandom_range(in_gap_max, in_gap_min);
         end
         if (in_q.size() == 0) begin
            in_valid = 1'b0;
            gap = $urandom_range(in_gap_max, in_gap_min);
         end else if (!in_valid) begin
            if (gap <= 0) begin
               in_valid = 1'b1;
               in_data = in_q[0];
            end else gap--;
         end
         hs = in_valid && in_ready && !rst;
      end
   end

   // output sink and done-pulse counter
   initial begin : out_drv
      out_ready = 1'b0;
      forever begin
         @(negedge clk);
         if (done) done_cnt++;
         case (out_mode)
            0:       out_ready = 1'($urandom_range(1, 0));
            1:       out_ready = 1'b0;
            default: out_ready = 1'b1;
         endcase
         if (out_valid && out_ready && !rst) out_q.push_back(out_data);
      end
   end

   task automatic applyStimulus(input logic [15:0] bias, input logic [9:0] nacc,
                                input logic [2:0] npool, input logic [9:0] prow,
                                input logic [9:0] nrow, input logic norm8, input int err_point);
      int np;
      txn_t t;
      logic [31:0] w;
      in_q.delete();
      @(negedge clk);
      @(negedge clk);
      exp_q.delete(); got_q.delete(); out_q.delete();
      done_cnt = 0; resp_idx = 0; err_at = err_point;
      np = (npool == 3'd0) ? 1 : int'(npool);
      t = '{we: 1'b1, be: 4'hF, addr: 32'h1000, wdata: {16'h0, bias}, gap: 0};
      exp_q.push_back(t);
      for (int p = 0; p < np; p++) begin
         for (int k = 0; k < int'(nacc); k++) begin
            w = $urandom;
            in_q.push_back(w);
            t = '{we: 1'b1, be: 4'hF, addr: 32'((int'(prow) + k) % 1024 * 4), wdata: w, gap: 0};
            exp_q.push_back(t);
         end
         t = '{we: 1'b1, be: 4'hF, addr: 32'h1004, wdata: {16'h0, bias}, gap: 0};
         exp_q.push_back(t);
      end
      t = '{we: 1'b1, be: (norm8 ? 4'h9 : 4'hB), addr: {20'h0, nrow, 2'b00}, wdata: 32'h0, gap: 0};
      exp_q.push_back(t);
      t = '{we: 1'b0, be: 4'hF, addr: 32'h100C, wdata: 32'h0, gap: 0};
      exp_q.push_back(t);
      exp_err = (err_point >= 0) && (err_point < exp_q.size());
      if (exp_err) while (exp_q.size() > err_point + 1) void'(exp_q.pop_back());
      exp_rdata = $urandom;
      read_data = exp_rdata;
      cfg_bias = bias; cfg_nacc = nacc; cfg_npool = npool;
      cfg_prow = prow; cfg_nrow = nrow; cfg_norm8 = norm8;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      check("busy_after_start", 72'(busy), 72'(1));
      check("err_cleared_by_start", 72'(err), 72'(0));
   endtask

   task automatic checkOutput();
      int n;
      int m;
      n = 0;
      while (done_cnt == 0 && n < 5000) begin
         @(negedge clk);
         n++;
      end
      check("done_in_time", 72'(n < 5000), 72'(1));
      @(negedge clk);
      @(negedge clk);
      check("done_pulses", 72'(done_cnt), 72'(1));
      check("busy_at_end", 72'(busy), 72'(0));
      check("txn_count", 72'(got_q.size()), 72'(exp_q.size()));
      m = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
      for (int i = 0; i < m; i++) begin
         check($sformatf("txn%0d", i),
               72'({got_q[i].we, got_q[i].be, got_q[i].addr, (got_q[i].we ? got_q[i].wdata : 32'h0)}),
               72'({exp_q[i].we, exp_q[i].be, exp_q[i].addr, (exp_q[i].we ? exp_q[i].wdata : 32'h0)}));
         if (!got_q[i].we)
            check("drain_gap", 72'(got_q[i].gap), 72'(DRAIN_CYC + 1));
      end
      check("err_flag", 72'(err), 72'(exp_err));
      if (exp_err) begin
         check("no_output_on_err", 72'(out_q.size()), 72'(0));
      end else begin
         check("out_count", 72'(out_q.size()), 72'(1));
         if (out_q.size() > 0) check("out_data", 72'(out_q[0]), 72'(exp_rdata));
         check("inputs_consumed", 72'(in_q.size()), 72'(0));
      end
   endtask

   task automatic set_timing(input int gmin, input int gmax, input int rmin, input int rmax,
                             input int imin, input int imax, input int omode);
      gnt_min = gmin; gnt_max = gmax; rv_min = rmin; rv_max = rmax;
      in_gap_min = imin; in_gap_max = imax; out_mode = omode;
   endtask

   initial begin : main
      int n;
      int ecount;
      rst = 1'b1; start = 1'b0;
      cfg_bias = '0; cfg_nacc = '0; cfg_npool = '0; cfg_prow = '0; cfg_nrow = '0; cfg_norm8 = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_busy", 72'(busy), 72'(0));
      check("rst_done", 72'(done), 72'(0));
      check("rst_err", 72'(err), 72'(0));
      check("rst_in_ready", 72'(in_ready), 72'(0));
      check("rst_out_valid", 72'(out_valid), 72'(0));
      check("rst_bus", 72'({p_req, p_we, p_be, p_addr, p_wdata}), 72'(0));
      rst = 1'b0;
      @(negedge clk);

      $display("[TB] single position");
      set_timing(0, 0, 0, 0, 0, 0, 2);
      applyStimulus(16'h0010, 10'd2, 3'd1, 10'd5, 10'd9, 1'b0, -1);
      read_data = 32'hA5A5_A5A5;
      exp_rdata = 32'hA5A5_A5A5;
      checkOutput();

      $display("[TB] backpressure");
      set_timing(4, 4, 0, 2, 5, 5, 0);
      applyStimulus(16'h1234, 10'd3, 3'd2, 10'd100, 10'd7, 1'b0, -1);
      checkOutput();

      $display("[TB] pooling");
      set_timing(0, 2, 0, 2, 0, 2, 2);
      applyStimulus(16'hBEEF, 10'd1, 3'd4, 10'd33, 10'd300, 1'b1, -1);
      checkOutput();

      $display("[TB] error on second acc response");
      set_timing(0, 1, 0, 1, 0, 1, 2);
      applyStimulus(16'h0042, 10'd2, 3'd1, 10'd12, 10'd20, 1'b0, 2);
      checkOutput();

      $display("[TB] nacc=0 npool=0");
      set_timing(0, 3, 0, 3, 0, 0, 0);
      applyStimulus(16'h00FF, 10'd0, 3'd0, 10'd50, 10'd1023, 1'b1, -1);
      checkOutput();

      $display("[TB] row wrap");
      set_timing(0, 1, 0, 1, 0, 3, 2);
      applyStimulus(16'h7777, 10'd2, 3'd1, 10'd1023, 10'd4, 1'b0, -1);
      checkOutput();

      $display("[TB] random runs");
      for (int r = 0; r < 10; r++) begin
         set_timing(0, 3, 0, 3, 0, 4, 0);
         ecount = ($urandom_range(3, 0) == 0) ? int'($urandom_range(12, 0)) : -1;
         applyStimulus(16'($urandom), 10'($urandom_range(5, 0)), 3'($urandom_range(7, 0)),
                       10'($urandom), 10'($urandom), 1'($urandom_range(1, 0)), ecount);
         checkOutput();
      end

      $display("[TB] start during OUT");
      set_timing(0, 1, 0, 1, 0, 1, 1);
      applyStimulus(16'h0101, 10'd1, 3'd2, 10'd8, 10'd9, 1'b1, -1);
      n = 0;
      while (!out_valid && n < 3000) begin
         @(negedge clk);
         n++;
      end
      check("out_valid_reached", 72'(out_valid), 72'(1));
      ecount = got_q.size();
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (3) @(negedge clk);
      check("out_held_valid", 72'(out_valid), 72'(1));
      check("out_held_busy", 72'(busy), 72'(1));
      check("out_held_data", 72'(out_data), 72'(exp_rdata));
      check("no_req_after_start_in_out", 72'(got_q.size()), 72'(ecount));
      out_mode = 2;
      checkOutput();

      $display("[TB] reset while waiting for grant");
      set_timing(40, 40, 0, 0, 0, 0, 2);
      applyStimulus(16'h0055, 10'd0, 3'd1, 10'd0, 10'd0, 1'b0, -1);
      n = 0;
      while (!p_req && n < 20) begin
         @(negedge clk);
         n++;
      end
      check("req_pending", 72'(p_req), 72'(1));
      rst = 1'b1;
      @(negedge clk);
      check("rst_mid_req", 72'(p_req), 72'(0));
      check("rst_mid_busy", 72'(busy), 72'(0));
      check("rst_mid_flags", 72'({done, err, in_ready, out_valid}), 72'(0));
      check("rst_mid_bus", 72'({p_we, p_be, p_addr, p_wdata}), 72'(0));
      @(negedge clk);
      rst = 1'b0;
      repeat (3) @(negedge clk);
      check("idle_after_rst", 72'({busy, p_req}), 72'(0));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
